// File: rtl/muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: funct3 op encodings, FSM states
// and small op-classification helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'b000,
        MULDIV_MULH   = 3'b001,
        MULDIV_MULHSU = 3'b010,
        MULDIV_MULHU  = 3'b011,
        MULDIV_DIV    = 3'b100,
        MULDIV_DIVU   = 3'b101,
        MULDIV_REM    = 3'b110,
        MULDIV_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX,
        MD_DONE
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input op_e op);
        return (op == MULDIV_MUL) || (op == MULDIV_MULH) || (op == MULDIV_MULHSU) ||
               (op == MULDIV_DIV) || (op == MULDIV_REM);
    endfunction

    function automatic logic op_b_signed(input op_e op);
        return (op == MULDIV_MUL) || (op == MULDIV_MULH) ||
               (op == MULDIV_DIV) || (op == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration on a {hi,lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_operand,
    input  logic              i_div,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_q_bit
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_trial;
    logic          w_q;

    assign w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    assign w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    assign w_trial  = w_rem_sh - {1'b0, i_operand};
    assign w_q      = ~w_trial[XLEN];

    // Quotient bit is returned separately and is 0 in multiply mode.
    always_comb begin
        o_q_bit = 1'b0;
        o_acc   = {w_sum, i_acc[XLEN-1:1]};
        if (i_div) begin
            o_q_bit = w_q;
            o_acc   = {(w_q ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0]), i_acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle '*' and skip CALC.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    op_e                 r_op;
    logic                r_neg_res, r_neg_rem;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;

    op_e                 w_op;
    logic                w_a_neg, w_b_neg, w_div_zero, w_ovf, w_special, w_fast, w_accept;
    logic [XLEN-1:0]     w_a_mag, w_b_mag, w_special_res, w_fix_res;
    logic [2*XLEN-1:0]   w_step_acc, w_prod;
    logic                w_q_bit;

    assign w_op          = op_e'(op);
    assign w_a_neg       = op_a_signed(w_op) & a[XLEN-1];
    assign w_b_neg       = op_b_signed(w_op) & b[XLEN-1];
    assign w_a_mag       = w_a_neg ? -a : a;
    assign w_b_mag       = w_b_neg ? -b : b;
    assign w_div_zero    = op_is_div(w_op) && (b == '0);
    assign w_ovf         = ((w_op == MULDIV_DIV) || (w_op == MULDIV_REM)) && (a == MIN_VAL) && (b == '1);
    assign w_special     = w_div_zero || w_ovf;
    // op[1] separates the remainder flavours from the quotient flavours.
    assign w_special_res = w_div_zero ? (w_op[1] ? a : '1) : (w_op[1] ? '0 : MIN_VAL);
    assign w_accept      = in_valid && in_ready;
    assign result        = r_result;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fa, w_fb;
    logic signed [2*XLEN-1:0] w_fast_prod;
    assign w_fa        = {op_a_signed(w_op) & a[XLEN-1], a};
    assign w_fb        = {op_b_signed(w_op) & b[XLEN-1], b};
    assign w_fast_prod = $signed({{(XLEN-1){w_fa[XLEN]}}, w_fa}) * $signed({{(XLEN-1){w_fb[XLEN]}}, w_fb});
    assign w_fast      = !op_is_div(w_op);
`else
    assign w_fast      = 1'b0;
`endif

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .i_div     (op_is_div(r_op)),
        .o_acc     (w_step_acc),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = (r_state == MD_IDLE) && !rst;
        out_valid = (r_state == MD_DONE);
        busy      = (r_state != MD_IDLE);
        unique case (r_state)
            MD_IDLE: if (w_accept) w_next = w_special ? MD_DONE : (w_fast ? MD_FIX : MD_CALC);
            MD_CALC: if (r_cnt == '0) w_next = MD_FIX;
            MD_FIX:  w_next = MD_DONE;
            MD_DONE: if (out_ready) w_next = MD_IDLE;
            default: w_next = MD_IDLE;
        endcase
        if (flush) w_next = MD_IDLE;
    end

    always_comb begin
        w_prod    = r_neg_res ? -r_acc : r_acc;
        w_fix_res = '0;
        case (r_op)
            MULDIV_MUL:                              w_fix_res = w_prod[XLEN-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            MULDIV_DIV, MULDIV_DIVU:                 w_fix_res = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            default:                                 w_fix_res = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        endcase
    end

    // NOTE: only the counter and the visible result are reset; the operand and
    // accumulator registers are always rewritten on accept before being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else if (!flush) begin
            unique case (r_state)
                MD_IDLE: if (w_accept) begin
                    r_op      <= w_op;
                    r_cnt     <= CNT_W'(XLEN - 1);
                    r_neg_res <= w_a_neg ^ w_b_neg;
                    r_neg_rem <= w_a_neg;
                    if (op_is_div(w_op)) begin
                        r_opnd <= w_b_mag;
                        r_acc  <= {{XLEN{1'b0}}, w_a_mag};
                    end else begin
                        r_opnd <= w_a_mag;
                        r_acc  <= {{XLEN{1'b0}}, w_b_mag};
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (w_fast) begin
                        r_acc     <= w_fast_prod;
                        r_neg_res <= 1'b0;
                    end
`endif
                    if (w_special) r_result <= w_special_res;
                end
                MD_CALC: begin
                    r_acc <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_q_bit};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                MD_FIX:  r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against
// a native-arithmetic reference, backpressure, flush, reset and an XLEN=64 instance.
module tb_muldiv_unit;

    localparam logic [31:0] MIN32 = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
    localparam int MUL_LAT64 = 2;
`else
    localparam int MUL_LAT = 34;
    localparam int MUL_LAT64 = 66;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        in_ready, out_valid, busy;

    logic        in_valid64, out_ready64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, result64;
    logic        in_ready64, out_valid64, busy64;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid64), .in_ready(in_ready64),
        .op(op64), .a(a64), .b(b64), .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .busy(busy64)
    );

    // Reference: RV32M semantics computed with 64-bit native arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, pu;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin pu = ux * uy; return pu[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
                p = sx / sy; return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                pu = ux / uy; return pu[31:0];
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'd0;
                p = sx % sy; return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                pu = ux % uy; return pu[31:0];
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && x == MIN32 && y == 32'hFFFF_FFFF) return 1;
        if (!o[2]) return MUL_LAT;
        return 34;
    endfunction

    // Called #1 after the accept edge; lat counts from the accept edge.
    task automatic wait_result(output logic [31:0] res, output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat <= 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(res, lat);
        if (guard >= 100) lat = -1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed;
        vec_t vecs [10];
        logic [31:0] res;
        int lat;
        vecs = '{
            '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd1, MIN32,        MIN32,        32'h4000_0000},
            '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF},
            '{3'd5, 32'd7,        32'd0,        32'hFFFF_FFFF},
            '{3'd6, MIN32,        32'hFFFF_FFFF, 32'd0},
            '{3'd4, MIN32,        32'hFFFF_FFFF, MIN32},
            '{3'd7, 32'd5,        32'd0,        32'd5}
        };
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, res, lat);
            n_cmp++;
            if (res !== vecs[i].e) begin
                n_err++; $display("FAIL directed_%0d_result: got %h expected %h", i, res, vecs[i].e);
            end
            n_cmp++;
            if (lat != exp_lat(vecs[i].o, vecs[i].x, vecs[i].y)) begin
                n_err++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, exp_lat(vecs[i].o, vecs[i].x, vecs[i].y));
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x, y, res, e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = MIN32; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 16));
                3: x = 32'($urandom_range(0, 100));
                4: y = -32'($urandom_range(1, 16));
                default: ;
            endcase
            e = model(o, x, y);
            run_op(o, x, y, res, lat);
            n_cmp++;
            if (res !== e) begin
                n_err++; $display("FAIL random_%0d op%0d a=%h b=%h: got %h expected %h", i, o, x, y, res, e);
            end
            n_cmp++;
            if (lat != exp_lat(o, x, y)) begin
                n_err++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, exp_lat(o, x, y));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        int lat;
        op = 3'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(res, lat);
        n_cmp++; if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL bp_result: got %h expected fffffffe", res); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold_%0d: got result=%h out_valid=%b in_ready=%b expected fffffffe 1 0", i, result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy); end
        wait_result(res, lat);
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL bp_next_result: got %h expected 0000000e", res); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] res;
        int lat;
        int seen;
        op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_calc: got busy=%b out_valid=%b expected 0 0", busy, out_valid);
        end
        op = 3'd5; a = 32'd50; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_drop_request: got busy=%b expected 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_output: got %0d valid cycles expected 0", seen); end
        run_op(3'd5, 32'd100, 32'd7, res, lat);
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL flush_after_result: got %h expected 0000000e", res); end
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL flush_after_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int lat;
        op = 3'd4; a = 32'd12345; b = 32'd11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready_comb: got %b expected 0", in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || result !== 32'd0) begin
            n_err++; $display("FAIL rstmid_state: got out_valid=%b busy=%b in_ready=%b result=%h expected 0 0 0 0", out_valid, busy, in_ready, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_release: got in_ready=%b expected 1", in_ready); end
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat);
        n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL rstmid_after_result: got %h expected ffffffeb", res); end
    endtask

    task automatic run_op64(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                            output logic [63:0] res, output int lat);
        op64 = o; a64 = x; b64 = y; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        lat = 1;
        while (out_valid64 !== 1'b1 && lat <= 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result64;
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        out_ready64 = 1'b0;
    endtask

    task automatic test_xlen64;
        logic [63:0] res;
        int lat;
        n_cmp++; if (in_ready64 !== 1'b1) begin n_err++; $display("FAIL x64_idle: got in_ready=%b expected 1", in_ready64); end
        run_op64(3'd0, 64'd1 << 40, 64'd1 << 20, res, lat);
        n_cmp++; if (res !== (64'd1 << 60)) begin n_err++; $display("FAIL x64_mul_result: got %h expected %h", res, 64'd1 << 60); end
        n_cmp++; if (lat != MUL_LAT64) begin n_err++; $display("FAIL x64_mul_latency: got %0d expected %0d", lat, MUL_LAT64); end
        run_op64(3'd5, 64'd1 << 60, 64'd1 << 20, res, lat);
        n_cmp++; if (res !== (64'd1 << 40)) begin n_err++; $display("FAIL x64_divu_result: got %h expected %h", res, 64'd1 << 40); end
        n_cmp++; if (lat != 66) begin n_err++; $display("FAIL x64_divu_latency: got %0d expected 66", lat); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 32'd0; b = 32'd0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; op64 = 3'd0; a64 = 64'd0; b64 = 64'd0;
        test_reset;
        test_directed;
        test_random;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_xlen64;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
